// File: rtl/series_pkg.sv
// Shared types for the parametrised series-evaluation controller:
// FSM state encoding and the bundle of datapath select/load strobes.
package series_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CAL_X = 3'd2,
    MULT  = 3'd3,
    ADD   = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic s1_rom;
    logic s1_x;
    logic s2_tmp;
    logic s2_x;
    logic s4_in;
    logic s4_mult;
    logic ld_x;
    logic ld_y;
    logic ld_tmp;
    logic init_tmp;
    logic ld_ans;
    logic init_ans;
    logic sub;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/term_counter.sv
// Term index and per-term multiply-step counter, with end-of-term and
// end-of-series flags for the controller FSM.
module term_counter #(
  parameter  int MAX_TERMS = 8,
  parameter  int POW_STEPS = 2,
  localparam int IW        = $clog2(MAX_TERMS),
  localparam int SW        = (POW_STEPS > 1) ? $clog2(POW_STEPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          step_clr_i,
  input  logic          step_inc_i,
  input  logic          term_inc_i,
  input  logic [IW-1:0] last_idx_i,
  output logic [IW-1:0] term_idx_o,
  output logic          step_last_o,
  output logic          term_last_o
);

  logic [IW-1:0] term_q;
  logic [SW-1:0] step_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_q <= '0;
      step_q <= '0;
    end else if (clr_i) begin
      term_q <= '0;
      step_q <= '0;
    end else begin
      if (term_inc_i) term_q <= term_q + 1'b1;
      if (step_clr_i)      step_q <= '0;
      else if (step_inc_i) step_q <= step_q + 1'b1;
    end
  end

  assign term_idx_o  = term_q;
  assign step_last_o = (step_q == SW'(POW_STEPS - 1));
  assign term_last_o = (term_q == last_idx_i);

endmodule

// File: rtl/series_ctrl_gen.sv
// Series-evaluation controller: load, x-power precompute, per-term multiply
// chain and signed accumulate, with runtime term count and busy/done handshake.
module series_ctrl_gen
  import series_pkg::*;
#(
  parameter  int MAX_TERMS = 8,
  parameter  int POW_STEPS = 2,
  localparam int TW        = $clog2(MAX_TERMS + 1),
  localparam int IW        = $clog2(MAX_TERMS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [TW-1:0] n_terms,
  input  logic          alt_mode,
  input  logic          less_cmp,
  output logic          s1_rom,
  output logic          s1_x,
  output logic          s2_tmp,
  output logic          s2_x,
  output logic          s4_in,
  output logic          s4_mult,
  output logic          ld_x,
  output logic          ld_y,
  output logic          ld_tmp,
  output logic          init_tmp,
  output logic          ld_ans,
  output logic          init_ans,
  output logic          sub,
  output logic [IW-1:0] term_idx,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          busy_q, done_q, alt_q;
  logic [IW-1:0] last_idx_q, last_idx_d;
  logic          step_last, term_last, term_end, accept;

  assign accept   = (state_q == IDLE) && start;
  assign term_end = less_cmp || term_last;

  // Zero or out-of-range requests run the full series.
  always_comb begin
    if (n_terms == '0 || n_terms > TW'(MAX_TERMS)) last_idx_d = IW'(MAX_TERMS - 1);
    else                                           last_idx_d = IW'(n_terms - 1'b1);
  end

  term_counter #(.MAX_TERMS(MAX_TERMS), .POW_STEPS(POW_STEPS)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (accept),
    .step_clr_i  ((state_q == CAL_X) || ((state_q == ADD) && !term_end)),
    .step_inc_i  ((state_q == MULT) && !step_last),
    .term_inc_i  ((state_q == ADD) && !term_end),
    .last_idx_i  (last_idx_q),
    .term_idx_o  (term_idx),
    .step_last_o (step_last),
    .term_last_o (term_last)
  );

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (!start) state_d = CAL_X;
      CAL_X:   state_d = MULT;
      MULT:    if (step_last) state_d = ADD;
      ADD:     state_d = term_end ? DONE : MULT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered, then registered.
  always_comb begin
    ctrl_d = CTRL_IDLE;
    case (state_d)
      LOAD: begin
        ctrl_d.s4_in = 1'b1;
        ctrl_d.ld_x  = 1'b1;
        ctrl_d.ld_y  = 1'b1;
      end
      CAL_X: begin
        ctrl_d.s1_x     = 1'b1;
        ctrl_d.s2_x     = 1'b1;
        ctrl_d.s4_mult  = 1'b1;
        ctrl_d.ld_x     = 1'b1;
        ctrl_d.init_tmp = 1'b1;
        ctrl_d.init_ans = 1'b1;
      end
      MULT: begin
        ctrl_d.s2_tmp = 1'b1;
        ctrl_d.ld_tmp = 1'b1;
        // First step of a term is entered from CAL_X or ADD; later ones from MULT.
        if (state_q == MULT) ctrl_d.s1_x   = 1'b1;
        else                 ctrl_d.s1_rom = 1'b1;
      end
      ADD: begin
        ctrl_d.ld_ans = 1'b1;
        ctrl_d.sub    = alt_q & term_idx[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ctrl_q     <= CTRL_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      alt_q      <= 1'b0;
      last_idx_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= (state_d == LOAD) || (state_d == CAL_X) ||
                 (state_d == MULT) || (state_d == ADD);
      done_q  <= (state_d == DONE);
      if (accept) begin
        alt_q      <= alt_mode;
        last_idx_q <= last_idx_d;
      end
    end
  end

  assign s1_rom   = ctrl_q.s1_rom;
  assign s1_x     = ctrl_q.s1_x;
  assign s2_tmp   = ctrl_q.s2_tmp;
  assign s2_x     = ctrl_q.s2_x;
  assign s4_in    = ctrl_q.s4_in;
  assign s4_mult  = ctrl_q.s4_mult;
  assign ld_x     = ctrl_q.ld_x;
  assign ld_y     = ctrl_q.ld_y;
  assign ld_tmp   = ctrl_q.ld_tmp;
  assign init_tmp = ctrl_q.init_tmp;
  assign ld_ans   = ctrl_q.ld_ans;
  assign init_ans = ctrl_q.init_ans;
  assign sub      = ctrl_q.sub;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_series_ctrl_gen.sv
// Self-checking bench: a default instance (8 terms, 2 steps) and a wide one
// (16 terms, 3 steps), checked cycle by cycle against a schedule model.
module tb_series_ctrl_gen;

  localparam int MA = 8,  PA = 2;
  localparam int MB = 16, PB = 3;

  typedef struct packed {
    logic s1_rom, s1_x, s2_tmp, s2_x, s4_in, s4_mult, ld_x, ld_y;
    logic ld_tmp, init_tmp, ld_ans, init_ans, sub, busy, done;
    logic [3:0] term;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   is_add;
    bit   is_idle;
    bit   is_done;
  } step_t;

  typedef struct {
    int    sel;
    int    n;
    bit    alt;
    int    hold;
    int    stop_at;
    bit    ign;
    int    exp_done;
    int    exp_term;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_start, a_alt, a_less;
  logic [3:0] a_n;
  logic       a_s1_rom, a_s1_x, a_s2_tmp, a_s2_x, a_s4_in, a_s4_mult, a_ld_x, a_ld_y;
  logic       a_ld_tmp, a_init_tmp, a_ld_ans, a_init_ans, a_sub, a_busy, a_done;
  logic [2:0] a_term;

  logic       b_start, b_alt, b_less;
  logic [4:0] b_n;
  logic       b_s1_rom, b_s1_x, b_s2_tmp, b_s2_x, b_s4_in, b_s4_mult, b_ld_x, b_ld_y;
  logic       b_ld_tmp, b_init_tmp, b_ld_ans, b_init_ans, b_sub, b_busy, b_done;
  logic [3:0] b_term;

  series_ctrl_gen #(.MAX_TERMS(MA), .POW_STEPS(PA)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .n_terms(a_n), .alt_mode(a_alt),
    .less_cmp(a_less), .s1_rom(a_s1_rom), .s1_x(a_s1_x), .s2_tmp(a_s2_tmp),
    .s2_x(a_s2_x), .s4_in(a_s4_in), .s4_mult(a_s4_mult), .ld_x(a_ld_x),
    .ld_y(a_ld_y), .ld_tmp(a_ld_tmp), .init_tmp(a_init_tmp), .ld_ans(a_ld_ans),
    .init_ans(a_init_ans), .sub(a_sub), .term_idx(a_term), .busy(a_busy),
    .done(a_done)
  );

  series_ctrl_gen #(.MAX_TERMS(MB), .POW_STEPS(PB)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .n_terms(b_n), .alt_mode(b_alt),
    .less_cmp(b_less), .s1_rom(b_s1_rom), .s1_x(b_s1_x), .s2_tmp(b_s2_tmp),
    .s2_x(b_s2_x), .s4_in(b_s4_in), .s4_mult(b_s4_mult), .ld_x(b_ld_x),
    .ld_y(b_ld_y), .ld_tmp(b_ld_tmp), .init_tmp(b_init_tmp), .ld_ans(b_ld_ans),
    .init_ans(b_init_ans), .sub(b_sub), .term_idx(b_term), .busy(b_busy),
    .done(b_done)
  );

  obs_t oa, ob;
  assign oa = '{a_s1_rom, a_s1_x, a_s2_tmp, a_s2_x, a_s4_in, a_s4_mult, a_ld_x, a_ld_y,
                a_ld_tmp, a_init_tmp, a_ld_ans, a_init_ans, a_sub, a_busy, a_done,
                {1'b0, a_term}};
  assign ob = '{b_s1_rom, b_s1_x, b_s2_tmp, b_s2_x, b_s4_in, b_s4_mult, b_ld_x, b_ld_y,
                b_ld_tmp, b_init_tmp, b_ld_ans, b_init_ans, b_sub, b_busy, b_done,
                b_term};

  int    errors = 0;
  int    checks = 0;
  step_t tr[$];

  task automatic check(input string nm, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic obs_t cur(input int sel);
    return (sel != 0) ? ob : oa;
  endfunction

  task automatic drive(input int sel, input logic st, input int n, input logic al,
                       input logic ls);
    if (sel != 0) begin
      b_start = st; b_n = 5'(n); b_alt = al; b_less = ls;
    end else begin
      a_start = st; a_n = 4'(n); a_alt = al; a_less = ls;
    end
  endtask

  // Expected per-cycle outputs, starting with the cycle after the edge that
  // accepts start: LOAD x hold, CAL_X, (POW_STEPS mults + add) per term, DONE, IDLE.
  function automatic int build(input int sel, input int n, input bit alt,
                               input int hold, input int stop_at);
    int    mx  = (sel != 0) ? MB : MA;
    int    p   = (sel != 0) ? PB : PA;
    int    eff = (n == 0 || n > mx) ? mx : n;
    int    used = (stop_at >= 1 && stop_at <= eff) ? stop_at : eff;
    step_t e;
    tr.delete();
    for (int h = 0; h < hold; h++) begin
      e = '{default: '0};
      e.o.s4_in = 1; e.o.ld_x = 1; e.o.ld_y = 1; e.o.busy = 1;
      tr.push_back(e);
    end
    e = '{default: '0};
    e.o.s1_x = 1; e.o.s2_x = 1; e.o.s4_mult = 1; e.o.ld_x = 1;
    e.o.init_tmp = 1; e.o.init_ans = 1; e.o.busy = 1;
    tr.push_back(e);
    for (int t = 0; t < used; t++) begin
      for (int k = 0; k < p; k++) begin
        e = '{default: '0};
        e.o.s2_tmp = 1; e.o.ld_tmp = 1; e.o.busy = 1; e.o.term = 4'(t);
        e.o.s1_rom = (k == 0); e.o.s1_x = (k != 0);
        tr.push_back(e);
      end
      e = '{default: '0};
      e.o.ld_ans = 1; e.o.busy = 1; e.o.term = 4'(t); e.is_add = 1;
      e.o.sub = alt && (t % 2 == 1);
      tr.push_back(e);
    end
    e = '{default: '0};
    e.o.done = 1; e.o.term = 4'(used - 1); e.is_done = 1;
    tr.push_back(e);
    e = '{default: '0};
    e.o.term = 4'(used - 1); e.is_idle = 1;
    tr.push_back(e);
    return used;
  endfunction

  // Called one time unit after a rising edge with both instances idle.
  task automatic run(input vec_t v);
    int   used, add_no, done_at, term_at;
    logic st, ls;
    used = build(v.sel, v.n, v.alt, v.hold, v.stop_at);
    drive(v.sel, 1'b1, v.n, v.alt, 1'($urandom_range(1, 0)));
    @(posedge clk); #1;
    add_no = 0; done_at = -1; term_at = -1;
    for (int i = 0; i < tr.size(); i++) begin
      check(v.name, i, 32'(cur(v.sel)), 32'(tr[i].o));
      if (cur(v.sel).done && done_at < 0) begin
        done_at = i;
        term_at = int'(cur(v.sel).term);
      end
      if (i < v.hold)           st = (i < v.hold - 1);
      else if (tr[i].is_idle)   st = 1'b0;
      else if (tr[i].is_done)   st = v.ign;
      else                      st = v.ign ? 1'($urandom_range(1, 0)) : 1'b0;
      if (tr[i].is_add) begin
        add_no++;
        ls = (add_no == v.stop_at);
      end else begin
        ls = 1'($urandom_range(1, 0));
      end
      if (v.ign && i >= v.hold)
        drive(v.sel, st, int'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), ls);
      else
        drive(v.sel, st, v.n, v.alt, ls);
      @(posedge clk); #1;
    end
    if (v.exp_done >= 0) begin
      check({v.name, "_done_edge"}, done_at, 32'(done_at), 32'(v.exp_done));
      check({v.name, "_final_term"}, done_at, 32'(term_at), 32'(v.exp_term));
    end
  endtask

  vec_t vecs[9];

  initial begin
    vec_t rv;
    int   mx;
    vecs[0] = '{0, 0,  1, 1, 0, 0, 26, 7,  "n0_alt_full"};
    vecs[1] = '{0, 8,  1, 1, 3, 0, 11, 2,  "less_3rd_add"};
    vecs[2] = '{0, 1,  0, 1, 0, 0, 5,  0,  "single_term"};
    vecs[3] = '{0, 12, 1, 1, 0, 0, 26, 7,  "clamp_12"};
    vecs[4] = '{0, 5,  1, 4, 0, 1, 20, 4,  "hold4_ignore"};
    vecs[5] = '{1, 16, 0, 1, 0, 0, 66, 15, "wide_16x3"};
    vecs[6] = '{1, 0,  1, 2, 5, 1, 23, 4,  "wide_less5"};
    vecs[7] = '{0, 2,  1, 1, 1, 0, 5,  0,  "less_first"};
    vecs[8] = '{0, 8,  0, 1, 8, 1, 26, 7,  "less_on_last"};

    rst = 1'b1;
    drive(0, 1'b0, 0, 1'b0, 1'b0);
    drive(1, 1'b0, 0, 1'b0, 1'b0);
    #12;
    check("reset_a", 0, 32'(oa), 32'd0);
    check("reset_b", 0, 32'(ob), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset during the second term's first multiply of a 3-term run.
    drive(0, 1'b1, 3, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 3, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_term", 5, 32'(oa.term), 32'd1);
    check("pre_rst_rom", 5, 32'(oa.s1_rom), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst", 0, 32'(oa), 32'd0);
    @(posedge clk); #1;
    check("rst_next_cycle", 0, 32'(oa), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[k]) run(vecs[k]);

    for (int r = 0; r < 24; r++) begin
      rv.sel     = int'($urandom_range(1, 0));
      mx         = (rv.sel != 0) ? MB : MA;
      rv.n       = int'($urandom_range((rv.sel != 0) ? 31 : 15, 0));
      rv.alt     = 1'($urandom_range(1, 0));
      rv.hold    = int'($urandom_range(3, 1));
      rv.stop_at = int'($urandom_range(mx + 1, 0));
      rv.ign     = 1'b1;
      rv.exp_done = -1;
      rv.exp_term = -1;
      rv.name    = $sformatf("rand%0d", r);
      run(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
